// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS-subset sequencer: one datapath step per clock, memory-ready
// stalls with a bounded wait, and sticky traps for illegal encodings and hung memory.
module multicycle_control_fsm #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opCode,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       PCSrc,
   output logic       IorD,
   output logic       MemReadEn,
   output logic       MemWriteEn,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWriteEn,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal,
   output logic       mem_err
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      WB_R     = 4'd3,
      EXEC_I   = 4'd4,
      WB_I     = 4'd5,
      MEM_ADDR = 4'd6,
      MEM_RD   = 4'd7,
      MEM_WB   = 4'd8,
      MEM_WR   = 4'd9,
      BRANCH   = 4'd10,
      TRAP     = 4'd11
   } state_t;

   state_t     st, nxt;
   logic [7:0] wait_cnt;
   logic       wait_st, tmo;
   logic       set_ill, set_merr;
   logic       r_ok;
   logic [2:0] r_op;
   logic       pc_wr, pc_wr_cond, ir_wr, reg_wr, mem_wr;

   assign state   = st;
   assign wait_st = (st == FETCH) || (st == MEM_RD) || (st == MEM_WR);
   // A same-cycle mem_ready always beats the timeout.
   assign tmo     = (MEM_TIMEOUT != 0) && (wait_cnt == 8'(MEM_TIMEOUT)) && !mem_ready;

   always_comb begin
      r_ok = 1'b1;
      r_op = 3'b000;
      case (funct)
         6'h20:   r_op = 3'b000;
         6'h22:   r_op = 3'b001;
         6'h24:   r_op = 3'b010;
         6'h25:   r_op = 3'b011;
         6'h2A:   r_op = 3'b100;
         default: r_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= FETCH;
         wait_cnt <= 8'd0;
         illegal  <= 1'b0;
         mem_err  <= 1'b0;
      end else begin
         st <= nxt;
         if (set_ill)  illegal <= 1'b1;
         if (set_merr) mem_err <= 1'b1;
         if ((nxt != st) || mem_ready || !wait_st)
            wait_cnt <= 8'd0;
         else if (wait_cnt != 8'hFF)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_comb begin
      nxt      = st;
      set_ill  = 1'b0;
      set_merr = 1'b0;
      case (st)
         FETCH: begin
            if (mem_ready) nxt = DECODE;
            else if (tmo) begin
               nxt      = TRAP;
               set_merr = 1'b1;
            end
         end
         DECODE: begin
            case (opCode)
               6'h00: begin
                  if (r_ok) nxt = EXEC_R;
                  else begin
                     nxt     = TRAP;
                     set_ill = 1'b1;
                  end
               end
               6'h08:        nxt = EXEC_I;
               6'h23, 6'h2B: nxt = MEM_ADDR;
               6'h04:        nxt = BRANCH;
               default: begin
                  nxt     = TRAP;
                  set_ill = 1'b1;
               end
            endcase
         end
         EXEC_R:   nxt = WB_R;
         WB_R:     nxt = FETCH;
         EXEC_I:   nxt = WB_I;
         WB_I:     nxt = FETCH;
         MEM_ADDR: nxt = (opCode == 6'h23) ? MEM_RD : MEM_WR;
         MEM_RD: begin
            if (mem_ready) nxt = MEM_WB;
            else if (tmo) begin
               nxt      = TRAP;
               set_merr = 1'b1;
            end
         end
         MEM_WB:   nxt = FETCH;
         MEM_WR: begin
            if (mem_ready) nxt = FETCH;
            else if (tmo) begin
               nxt      = TRAP;
               set_merr = 1'b1;
            end
         end
         BRANCH:   nxt = FETCH;
         TRAP:     nxt = TRAP;
         default: begin
            nxt     = TRAP;
            set_ill = 1'b1;
         end
      endcase
   end

   always_comb begin
      pc_wr      = 1'b0;
      pc_wr_cond = 1'b0;
      ir_wr      = 1'b0;
      reg_wr     = 1'b0;
      mem_wr     = 1'b0;
      PCSrc      = 1'b0;
      IorD       = 1'b0;
      MemReadEn  = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 3'b000;
      instr_done = 1'b0;
      case (st)
         FETCH: begin
            MemReadEn = 1'b1;
            ALUSrcB   = 2'b01;
            ir_wr     = mem_ready;
            pc_wr     = mem_ready;
         end
         DECODE:   ALUSrcB = 2'b11;
         EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = r_op;
         end
         WB_R: begin
            RegDst     = 1'b1;
            reg_wr     = 1'b1;
            instr_done = 1'b1;
         end
         EXEC_I, MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         WB_I: begin
            reg_wr     = 1'b1;
            instr_done = 1'b1;
         end
         MEM_RD: begin
            IorD      = 1'b1;
            MemReadEn = 1'b1;
         end
         MEM_WB: begin
            MemtoReg   = 1'b1;
            reg_wr     = 1'b1;
            instr_done = 1'b1;
         end
         MEM_WR: begin
            IorD       = 1'b1;
            mem_wr     = 1'b1;
            instr_done = mem_ready;
         end
         BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUOp      = 3'b001;
            pc_wr_cond = 1'b1;
            PCSrc      = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   // Write strobes are killed combinationally so nothing commits in a reset cycle.
   assign PCWrite     = pc_wr      & ~rst;
   assign PCWriteCond = pc_wr_cond & ~rst;
   assign IRWrite     = ir_wr      & ~rst;
   assign RegWriteEn  = reg_wr     & ~rst;
   assign MemWriteEn  = mem_wr     & ~rst;

endmodule
